// File: rtl/osc_model_mphase_if.sv
// Signal bundle between the multi-phase oscillator model and its emulation environment.
// The global timestep manager drives the grant side (master); the oscillator is the slave.
interface osc_model_mphase_if #(
  parameter int N_PHASES  = 4,
  parameter int DT_WIDTH  = 25,
  parameter int CNT_WIDTH = 16
);
  // Timestep handshake, one exchange per emu_clk cycle:
  //   dt_req  - slave asks for at most this much time to elapse (all ones = no constraint).
  //   emu_dt  - master grants time for this cycle (global min of all requests); 0 means
  //             time does not advance. A grant above dt_req is a protocol error.
  logic [DT_WIDTH-1:0]  emu_dt;
  logic                 en;
  logic [DT_WIDTH-1:0]  step_i;
  logic [DT_WIDTH-1:0]  dt_req;
  logic [N_PHASES-1:0]  clk_val;
  logic                 edge_o;
  logic [CNT_WIDTH-1:0] period_cnt;
  logic                 dt_err;

  modport master (
    output emu_dt, en, step_i,
    input  dt_req, clk_val, edge_o, period_cnt, dt_err
  );

  modport slave (
    input  emu_dt, en, step_i,
    output dt_req, clk_val, edge_o, period_cnt, dt_err
  );
endinterface

// File: rtl/osc_model_mphase.sv
// Multi-phase oscillator model: 2*N_PHASES edges per period, phases 180/N_PHASES deg apart,
// advancing on granted emulation timesteps and requesting the time left to its next edge.
module osc_model_mphase #(
  parameter int N_PHASES  = 4,
  parameter int DT_WIDTH  = 25,
  parameter int CNT_WIDTH = 16,
  parameter int INIT_DLY  = 1
) (
  input  logic              emu_clk,
  input  logic              emu_rst,
  osc_model_mphase_if.slave bus
);

  localparam int N_EDGES = 2 * N_PHASES;
  localparam int IDX_W   = (N_EDGES > 2) ? $clog2(N_EDGES) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_EDGES - 1);
  localparam logic [DT_WIDTH-1:0] DT_ONE   = DT_WIDTH'(1);
  localparam logic [DT_WIDTH-1:0] DT_INIT  = DT_WIDTH'(INIT_DLY);

  // Registered state
  logic [DT_WIDTH-1:0]  r_t_rem;
  logic [IDX_W-1:0]     r_idx;
  logic [N_PHASES-1:0]  r_clk_val;
  logic [CNT_WIDTH-1:0] r_period_cnt;
  logic                 r_dt_err;
  logic                 r_edge;

  // Decode of the current cycle
  logic [DT_WIDTH-1:0]  w_step_eff;
  logic [N_PHASES-1:0]  w_toggle;
  logic                 w_grant;
  logic                 w_hit;
  logic                 w_over;
  logic                 w_wrap;

  // Next-state values
  logic [DT_WIDTH-1:0]  w_t_rem_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [N_PHASES-1:0]  w_clk_val_nxt;
  logic [CNT_WIDTH-1:0] w_period_cnt_nxt;
  logic                 w_dt_err_nxt;

  always_comb begin
    w_step_eff = (bus.step_i == '0) ? DT_ONE : bus.step_i;
  end

  // Edge idx and idx+N_PHASES act on the same phase: first a rise, then a fall.
  always_comb begin
    w_toggle = '0;
    for (int i = 0; i < N_PHASES; i++) begin
      w_toggle[i] = (r_idx == IDX_W'(i)) || (r_idx == IDX_W'(i + N_PHASES));
    end
  end

  always_comb begin
    w_grant = bus.en && (bus.emu_dt != '0);
    w_hit   = w_grant && (bus.emu_dt >= r_t_rem);
    w_over  = w_grant && (bus.emu_dt >  r_t_rem);
    w_wrap  = w_hit && (r_idx == LAST_IDX);
  end

  // An overshooting grant still lands exactly on the edge; the excess is dropped.
  always_comb begin
    w_t_rem_nxt = r_t_rem;
    if (!bus.en) begin
      w_t_rem_nxt = w_step_eff;
    end else if (w_hit) begin
      w_t_rem_nxt = w_step_eff;
    end else if (w_grant) begin
      w_t_rem_nxt = r_t_rem - bus.emu_dt;
    end
  end

  always_comb begin
    w_idx_nxt        = r_idx;
    w_clk_val_nxt    = r_clk_val;
    w_period_cnt_nxt = r_period_cnt;
    w_dt_err_nxt     = r_dt_err | w_over;
    if (w_hit) begin
      w_idx_nxt     = w_wrap ? '0 : (r_idx + IDX_W'(1));
      w_clk_val_nxt = r_clk_val ^ w_toggle;
    end
    if (w_wrap) begin
      w_period_cnt_nxt = r_period_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      r_t_rem      <= DT_INIT;
      r_idx        <= '0;
      r_clk_val    <= '0;
      r_period_cnt <= '0;
      r_dt_err     <= 1'b0;
      r_edge       <= 1'b0;
    end else begin
      r_t_rem      <= w_t_rem_nxt;
      r_idx        <= w_idx_nxt;
      r_clk_val    <= w_clk_val_nxt;
      r_period_cnt <= w_period_cnt_nxt;
      r_dt_err     <= w_dt_err_nxt;
      r_edge       <= w_hit;
    end
  end

  // A disabled oscillator must not limit the global timestep.
  assign bus.dt_req     = bus.en ? r_t_rem : '1;
  assign bus.clk_val    = r_clk_val;
  assign bus.edge_o     = r_edge;
  assign bus.period_cnt = r_period_cnt;
  assign bus.dt_err     = r_dt_err;

endmodule
